tone_period_meter: RTL and testbench
====================================

TONE_PERIOD_METER -- requirements
Module: tone_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the half-period counter and the half_period output.
REQ-002 SHALL have parameter MIN_HALF, default 4: minimum accepted half-period in clk cycles; closer edges are glitches.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port speaker_in  input  1  asynchronous square-wave tone input, e.g. a divider-driven speaker line.
REQ-006 SHALL have port half_period  output  CNT_W  last accepted edge-to-edge interval, in clk cycles.
REQ-007 SHALL have port divider  output  CNT_W  reconstructed generator reload value, equal to half_period-1.
REQ-008 SHALL have port period_valid  output  1  one-cycle pulse when half_period/divider update.
REQ-009 SHALL have port silent  output  1  level; high when no tone is present.
REQ-010 SHALL have port sweep_dir  output  2  trend of consecutive measurements; see REQ-027.

Function
REQ-011 SHALL pass speaker_in through a 2-flop synchronizer, then a third register for edge detection.
REQ-012 SHALL treat a rising or a falling synchronized transition as an edge.
REQ-013 SHALL implement states IDLE and MEASURE.
REQ-014 IDLE: first edge -> MEASURE with count=1; no period_valid on this edge.
REQ-015 MEASURE: count increments by 1 every cycle with no edge.
REQ-016 MEASURE, edge with count>=MIN_HALF: half_period<=count, divider<=count-1, period_valid=1 next cycle, count<=1, silent<=0.
REQ-017 MEASURE, edge with count<MIN_HALF: glitch; edge ignored, count keeps incrementing, no outputs change.
REQ-018 MEASURE, count reaching 2^CNT_W-1 with no edge: silent<=1, state<=IDLE, count<=0; half_period and divider hold.
REQ-019 Edge on the same cycle count saturates: the edge wins (REQ-016 applies), silent stays low.
REQ-020 A square wave toggling every N clk cycles (MIN_HALF<=N<2^CNT_W-1) SHALL yield half_period=N on every valid after the first.
REQ-021 Latency: period_valid SHALL assert 4 clk cycles after the speaker_in transition that completes the interval.
REQ-022 period_valid SHALL never be high on two consecutive cycles.

Reset
REQ-023 rst_n low at a clk edge SHALL force state=IDLE, count=0, synchronizer/edge regs=0, half_period=0, divider=0, period_valid=0, silent=1, sweep_dir=2'b00.
REQ-024 Reset asserted mid-MEASURE SHALL abandon the measurement; no period_valid for the partial interval.
REQ-025 After rst_n rises, the first edge SHALL be handled per REQ-014; a high speaker_in at release does not by itself count as an edge.

Configuration
REQ-026 Macro TONE_METER_SWEEP_EN SHALL select the sweep-trend feature.
REQ-027 Defined: on each period_valid after the first valid following IDLE, sweep_dir SHALL be 2'b01 if the new half_period > previous, 2'b10 if lower, 2'b00 if equal; it holds between valids and clears to 2'b00 on entering IDLE.
REQ-028 Not defined: sweep_dir SHALL be constant 2'b00 and the previous-value register SHALL be absent.

Verification
REQ-029 Toggle speaker_in every 100 cycles -> first valid after the 2nd input edge; half_period=100, divider=99, valid every 100 cycles, silent=0.
REQ-030 Stable wave at N=100, then a 2-cycle glitch pulse mid-interval -> both glitch edges ignored; the next valid still reports 100, then 100s resume.
REQ-031 Toggle every 200 cycles, then hold speaker_in constant -> silent=1 exactly 65535 cycles after the last accepted edge; half_period stays 200.
REQ-032 Assert rst_n=0 for 1 cycle, 50 cycles into a 100-cycle interval -> all outputs at reset values, no valid for that interval; the next valid comes one full interval after re-acquisition.
REQ-033 With TONE_METER_SWEEP_EN: intervals 100,100,120,90 -> sweep_dir 00,00,01,10; without the macro -> sweep_dir=00 throughout.
REQ-034 Interval of exactly MIN_HALF=4 -> accepted, half_period=4; interval of 3 -> ignored.

Source files
------------

// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the half-period of a square-wave tone input and reconstructs its divider.
// Defining TONE_METER_SWEEP_EN adds the sweep_dir trend of consecutive measurements.
module tone_period_meter #(
    parameter int CNT_W    = 16,
    parameter int MIN_HALF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             speaker_in,
    output logic [CNT_W-1:0] half_period,
    output logic [CNT_W-1:0] divider,
    output logic             period_valid,
    output logic             silent,
    output logic [1:0]       sweep_dir
);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t state;
    logic s1, s2, s3, tone_edge;
    logic [1:0] fill;
    logic [CNT_W-1:0] count;
    logic accept, timeout;
    assign accept  = state == MEASURE && tone_edge && count >= CNT_W'(MIN_HALF);
    assign timeout = state == MEASURE && !accept && count == '1;
    // fill masks the bogus s2/s3 mismatch while the pipeline reloads after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1, s2, s3, tone_edge} <= '0;
            fill <= '0;
        end else begin
            s1 <= speaker_in;
            s2 <= s1;
            s3 <= s2;
            fill <= fill + {1'b0, fill != 2'd3};
            tone_edge <= fill == 2'd3 && s2 != s3;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            half_period <= '0;
            divider <= '0;
            period_valid <= 1'b0;
            silent <= 1'b1;
        end else begin
            period_valid <= accept;
            if (accept) begin
                half_period <= count;
                divider <= count - 1'b1;
                count <= CNT_W'(1);
                silent <= 1'b0;
            end else if (timeout) begin
                state <= IDLE;
                count <= '0;
                silent <= 1'b1;
            end else if (state == IDLE && tone_edge) begin
                state <= MEASURE;
                count <= CNT_W'(1);
            end else if (state == MEASURE) begin
                count <= count + 1'b1;
            end
        end
    end
`ifdef TONE_METER_SWEEP_EN
    logic [CNT_W-1:0] prev;
    logic have_prev;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= '0;
            have_prev <= 1'b0;
            sweep_dir <= 2'b00;
        end else if (accept) begin
            prev <= count;
            have_prev <= 1'b1;
            if (have_prev) sweep_dir <= count > prev ? 2'b01 : count < prev ? 2'b10 : 2'b00;
        end else if (timeout) begin
            have_prev <= 1'b0;
            sweep_dir <= 2'b00;
        end
    end
`else
    assign sweep_dir = 2'b00;
`endif
endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: randomized and directed stimulus checked every cycle against an elapsed-time model.
module tb_tone_period_meter;
    localparam int MIN_HALF = 4;
    localparam int SAT = 65535;
`ifdef TONE_METER_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, speaker_in = 1'b0;
    logic [15:0] half_period, divider;
    logic period_valid, silent;
    logic [1:0] sweep_dir;

    tone_period_meter dut (
        .clk(clk), .rst_n(rst_n), .speaker_in(speaker_in),
        .half_period(half_period), .divider(divider),
        .period_valid(period_valid), .silent(silent), .sweep_dir(sweep_dir)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int q[$];
    bit active = 1'b0, have_prev = 1'b0, m_valid = 1'b0, m_silent = 1'b1;
    int t_last = 0;
    logic [15:0] m_hp = '0, m_div = '0;
    logic [1:0] m_sweep = '0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Model works on the time between accepted edges, as seen 4 cycles after each input toggle
    task automatic model_step(bit in_reset);
        bit edge_now;
        int dt;
        m_valid = 1'b0;
        if (in_reset) begin
            active = 1'b0; have_prev = 1'b0; m_silent = 1'b1;
            m_hp = '0; m_div = '0; m_sweep = '0;
            q.delete();
            return;
        end
        edge_now = q.size() > 0 && q[0] == cyc;
        if (edge_now) void'(q.pop_front());
        dt = cyc - t_last;
        if (active && edge_now && dt >= MIN_HALF) begin
            if (SWEEP && have_prev) m_sweep = dt > int'(m_hp) ? 2'b01 : dt < int'(m_hp) ? 2'b10 : 2'b00;
            m_hp = 16'(dt);
            m_div = 16'(dt - 1);
            have_prev = 1'b1; m_valid = 1'b1; m_silent = 1'b0; t_last = cyc;
        end else if (active && dt >= SAT) begin
            active = 1'b0; have_prev = 1'b0; m_sweep = '0; m_silent = 1'b1;
        end else if (!active && edge_now) begin
            active = 1'b1; t_last = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step(!rst_n);
        #1;
        check("valid", 32'(period_valid), 32'(m_valid));
        check("silent", 32'(silent), 32'(m_silent));
        check("half_period", 32'(half_period), 32'(m_hp));
        check("divider", 32'(divider), 32'(m_div));
        check("sweep_dir", 32'(sweep_dir), 32'(m_sweep));
    endtask

    task automatic wait_n(int n);
        repeat (n) tick();
    endtask

    task automatic toggle();
        speaker_in = ~speaker_in;
        q.push_back(cyc + 4);
    endtask

    task automatic wave(int n, int reps);
        repeat (reps) begin
            toggle();
            wait_n(n);
        end
    endtask

    initial begin
        wait_n(5);
        rst_n = 1'b1;
        wait_n(5);
        wave(100, 6);
        // 2-cycle pulse right after an accepted edge: both edges fall inside MIN_HALF
        toggle(); wait_n(1);
        toggle(); wait_n(2);
        toggle(); wait_n(97);
        wave(100, 3);
        toggle(); wait_n(4);
        toggle(); wait_n(3);
        toggle(); wait_n(10);
        toggle(); wait_n(10);
        wave(200, 4);
        wait_n(65600);
        check("hp_after_silence", 32'(half_period), 32'd200);
        check("silent_after_hold", 32'(silent), 32'd1);
        toggle(); wait_n(100);
        toggle(); wait_n(100);
        toggle(); wait_n(120);
        toggle(); wait_n(90);
        toggle(); wait_n(10);
        wave(100, 3);
        toggle(); wait_n(50);
        rst_n = 1'b0; tick();
        rst_n = 1'b1; wait_n(50);
        wave(100, 3);
        repeat (60) begin
            toggle();
            wait_n(int'($urandom_range(1, 250)));
        end
        wait_n(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
